// File: rtl/tone_osc.sv
// Square-wave tone oscillator: accepts a period divider over valid/ready and
// applies it only at a period boundary (or at once while silent).
module tone_osc #(
  parameter int DIV_W   = 19,
  parameter int MIN_DIV = 2
) (
  input  logic             hwclk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             enable,
  output logic             wave_out,
  output logic             period_tick,
  output logic [DIV_W-1:0] active_div
);

  typedef enum logic {
    ST_SILENT = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  localparam logic [DIV_W-1:0] ONE_V     = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] ZERO_V    = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] active_q, active_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             shadow_full_q, shadow_full_d;
  logic             wave_q, wave_d;
  logic             tick_q, tick_d;
  logic             xfer_s;
  logic             run_now_s;
  logic             boundary_s;

  assign div_ready   = !shadow_full_q;
  assign wave_out    = wave_q;
  assign period_tick = tick_q;
  assign active_div  = active_q;

  // Next-state logic; registered outputs are derived from the next count/divider
  // so that wave_out and period_tick line up with the cycle they describe.
  always_comb begin
    xfer_s        = div_valid && !shadow_full_q;
    boundary_s    = (count_q == (active_q - ONE_V));
    active_d      = active_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    count_d       = ZERO_V;
    state_d       = ST_SILENT;

    case (state_q)
      ST_RUN:    run_now_s = enable;
      ST_SILENT: run_now_s = 1'b0;
      default:   run_now_s = 1'b0;
    endcase

    if (run_now_s) begin
      if (boundary_s) begin
        if (shadow_full_q) begin
          active_d      = shadow_q;
          shadow_full_d = 1'b0;
        end else if (xfer_s) begin
          active_d = div_in;
        end else begin
          active_d = active_q;
        end
      end else begin
        count_d = count_q + ONE_V;
        if (xfer_s) begin
          shadow_d      = div_in;
          shadow_full_d = 1'b1;
        end else begin
          shadow_d = shadow_q;
        end
      end
    end else begin
      // Silent: nothing audible to protect, so a new divider applies at once.
      if (shadow_full_q) begin
        active_d      = shadow_q;
        shadow_full_d = 1'b0;
      end else if (xfer_s) begin
        active_d = div_in;
      end else begin
        active_d = active_q;
      end
    end

    if (enable && (active_d >= MIN_DIV_V)) begin
      state_d = ST_RUN;
    end else begin
      state_d = ST_SILENT;
      count_d = ZERO_V;
    end

    wave_d = (state_d == ST_RUN) && (count_d < (active_d >> 1));
    tick_d = (state_d == ST_RUN) && (count_d == (active_d - ONE_V));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      state_q       <= ST_SILENT;
      count_q       <= ZERO_V;
      active_q      <= ZERO_V;
      shadow_q      <= ZERO_V;
      shadow_full_q <= 1'b0;
      wave_q        <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      wave_q        <= wave_d;
      tick_q        <= tick_d;
    end
  end

endmodule
